// File: rtl/mem_port_arbiter.sv
// Shares one single-port synchronous BRAM between instruction fetch and the
// load/store port: data wins ties, with a streak limit so fetch always progresses.
module mem_port_arbiter #(
  parameter int AWIDTH        = 14,
  parameter int MEM_LAT       = 1,
  parameter int MAX_DM_STREAK = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [31:0]       if_addr,
  output logic              if_valid,
  output logic [31:0]       if_rdata,
  input  logic              dm_req,
  input  logic [3:0]        dm_we,
  input  logic [31:0]       dm_addr,
  input  logic [31:0]       dm_wdata,
  output logic              dm_valid,
  output logic [31:0]       dm_rdata,
  output logic              mem_en,
  output logic [3:0]        mem_we,
  output logic [AWIDTH-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);
  localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam int SW = $clog2(MAX_DM_STREAK + 1);
  localparam logic [CW-1:0] WAIT_INIT  = CW'(MEM_LAT - 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DM_STREAK);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t              state, state_nxt;
  logic                owner_dm, owner_dm_nxt;
  logic                is_store, is_store_nxt;
  logic [CW-1:0]       wait_cnt, wait_cnt_nxt;
  logic [SW-1:0]       streak, streak_nxt;
  logic                mem_en_nxt;
  logic [3:0]          mem_we_nxt;
  logic [AWIDTH-1:0]   mem_addr_nxt;
  logic [31:0]         mem_wdata_nxt;
  logic                if_valid_nxt, dm_valid_nxt;
  logic [31:0]         if_rdata_nxt, dm_rdata_nxt;
  logic                data_grant;

  // Byte-offset and out-of-range address bits are deliberately dropped.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{if_addr[31:AWIDTH+2], if_addr[1:0],
                              dm_addr[31:AWIDTH+2], dm_addr[1:0]};

  // Fetch only wins a tie once data has used up its streak allowance.
  assign data_grant = dm_req && !(if_req && (streak == STREAK_MAX));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    owner_dm_nxt  = owner_dm;
    is_store_nxt  = is_store;
    wait_cnt_nxt  = wait_cnt;
    streak_nxt    = streak;
    mem_en_nxt    = mem_en;
    mem_we_nxt    = mem_we;
    mem_addr_nxt  = mem_addr;
    mem_wdata_nxt = mem_wdata;
    if_valid_nxt  = 1'b0;
    dm_valid_nxt  = 1'b0;
    if_rdata_nxt  = if_rdata;
    dm_rdata_nxt  = dm_rdata;
    unique case (state)
      IDLE: begin
        if (!if_req) streak_nxt = '0;
        if (data_grant) begin
          owner_dm_nxt  = 1'b1;
          is_store_nxt  = |dm_we;
          mem_en_nxt    = 1'b1;
          mem_we_nxt    = dm_we;
          mem_addr_nxt  = dm_addr[AWIDTH+1:2];
          mem_wdata_nxt = dm_wdata;
          state_nxt     = ISSUE;
          if (if_req) streak_nxt = streak + SW'(1);
        end else if (if_req) begin
          owner_dm_nxt  = 1'b0;
          is_store_nxt  = 1'b0;
          mem_en_nxt    = 1'b1;
          mem_we_nxt    = 4'b0000;
          mem_addr_nxt  = if_addr[AWIDTH+1:2];
          mem_wdata_nxt = '0;
          state_nxt     = ISSUE;
          streak_nxt    = '0;
        end
      end
      ISSUE: begin
        mem_en_nxt = 1'b0;
        mem_we_nxt = 4'b0000;
        if (is_store) begin
          dm_valid_nxt = 1'b1;
          dm_rdata_nxt = '0;
          state_nxt    = RESP;
        end else begin
          wait_cnt_nxt = WAIT_INIT;
          state_nxt    = WAIT;
        end
      end
      WAIT: begin
        if (wait_cnt == '0) begin
          if (owner_dm) begin
            dm_rdata_nxt = mem_rdata;
            dm_valid_nxt = 1'b1;
          end else begin
            if_rdata_nxt = mem_rdata;
            if_valid_nxt = 1'b1;
          end
          state_nxt = RESP;
        end else begin
          wait_cnt_nxt = wait_cnt - CW'(1);
        end
      end
      RESP: begin
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Reset clears data outputs too, so a dropped transaction leaves nothing visible.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_dm  <= 1'b0;
      is_store  <= 1'b0;
      wait_cnt  <= '0;
      streak    <= '0;
      mem_en    <= 1'b0;
      mem_we    <= 4'b0000;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_valid  <= 1'b0;
      dm_valid  <= 1'b0;
      if_rdata  <= '0;
      dm_rdata  <= '0;
    end else begin
      owner_dm  <= owner_dm_nxt;
      is_store  <= is_store_nxt;
      wait_cnt  <= wait_cnt_nxt;
      streak    <= streak_nxt;
      mem_en    <= mem_en_nxt;
      mem_we    <= mem_we_nxt;
      mem_addr  <= mem_addr_nxt;
      mem_wdata <= mem_wdata_nxt;
      if_valid  <= if_valid_nxt;
      dm_valid  <= dm_valid_nxt;
      if_rdata  <= if_rdata_nxt;
      dm_rdata  <= dm_rdata_nxt;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: BRAM models behind a MEM_LAT=1 and a MEM_LAT=3
// instance, with per-port scoreboards of expected read data.
module tb_mem_port_arbiter;
  localparam int AW   = 14;
  localparam int MAXS = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   cyc   = 0;
  int   n_cmp = 0;
  int   n_fail = 0;

  logic          if_req = 1'b0, dm_req = 1'b0;
  logic [31:0]   if_addr = '0, dm_addr = '0, dm_wdata = '0;
  logic [3:0]    dm_we = '0;
  logic          if_valid, dm_valid, mem_en;
  logic [31:0]   if_rdata, dm_rdata, mem_wdata, mem_rdata;
  logic [3:0]    mem_we;
  logic [AW-1:0] mem_addr;

  logic          l3_if_req = 1'b0, l3_dm_req = 1'b0;
  logic [31:0]   l3_if_addr = '0, l3_dm_addr = '0, l3_dm_wdata = '0;
  logic [3:0]    l3_dm_we = '0;
  logic          l3_if_valid, l3_dm_valid, l3_mem_en;
  logic [31:0]   l3_if_rdata, l3_dm_rdata, l3_mem_wdata, l3_mem_rdata;
  logic [3:0]    l3_mem_we;
  logic [AW-1:0] l3_mem_addr;

  logic          pre_we = 1'b0;
  logic [AW-1:0] pre_a = '0;
  logic [31:0]   pre_d = '0;

  logic [31:0] bram [0:16383];
  logic [31:0] bram3 [0:31];
  logic [31:0] ref_mem [0:255];
  logic [31:0] rd_p0, rd3_p0, rd3_p1, rd3_p2;

  logic [31:0] q_if [$];
  logic [32:0] q_dm [$];

  mem_port_arbiter #(.AWIDTH(AW), .MEM_LAT(1), .MAX_DM_STREAK(MAXS)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_valid(if_valid), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_valid(dm_valid), .dm_rdata(dm_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  mem_port_arbiter #(.AWIDTH(AW), .MEM_LAT(3), .MAX_DM_STREAK(MAXS)) dut3 (
    .clk(clk), .rst_n(rst_n),
    .if_req(l3_if_req), .if_addr(l3_if_addr), .if_valid(l3_if_valid), .if_rdata(l3_if_rdata),
    .dm_req(l3_dm_req), .dm_we(l3_dm_we), .dm_addr(l3_dm_addr), .dm_wdata(l3_dm_wdata),
    .dm_valid(l3_dm_valid), .dm_rdata(l3_dm_rdata),
    .mem_en(l3_mem_en), .mem_we(l3_mem_we), .mem_addr(l3_mem_addr), .mem_wdata(l3_mem_wdata),
    .mem_rdata(l3_mem_rdata)
  );

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  function automatic logic [116:0] main_outs();
    return {if_valid, dm_valid, mem_en, mem_we, mem_addr, mem_wdata, if_rdata, dm_rdata};
  endfunction

  function automatic logic [116:0] l3_outs();
    return {l3_if_valid, l3_dm_valid, l3_mem_en, l3_mem_we, l3_mem_addr, l3_mem_wdata,
            l3_if_rdata, l3_dm_rdata};
  endfunction

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // BRAM with one-cycle read latency; returns junk when not reading.
  always @(posedge clk) begin
    if (pre_we) bram[pre_a] <= pre_d;
    else if (mem_en && mem_we != 4'b0000) bram[mem_addr] <= merge(bram[mem_addr], mem_wdata, mem_we);
    rd_p0 <= (mem_en && mem_we == 4'b0000) ? bram[mem_addr] : 32'hDEAD_BEEF;
  end
  assign mem_rdata = rd_p0;

  // BRAM with three-cycle read latency.
  always @(posedge clk) begin
    if (pre_we) bram3[pre_a[4:0]] <= pre_d;
    rd3_p0 <= (l3_mem_en && l3_mem_we == 4'b0000) ? bram3[l3_mem_addr[4:0]] : 32'hDEAD_BEEF;
    rd3_p1 <= rd3_p0;
    rd3_p2 <= rd3_p1;
  end
  assign l3_mem_rdata = rd3_p2;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input int budget, output int at_cyc, output logic got_if,
                            output logic got_dm, output logic timed_out);
    at_cyc = -1; got_if = 1'b0; got_dm = 1'b0; timed_out = 1'b1;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (if_valid || dm_valid) begin
        at_cyc = cyc; got_if = if_valid; got_dm = dm_valid; timed_out = 1'b0;
        break;
      end
    end
  endtask

  task automatic preload(input int a, input logic [31:0] d);
    pre_we = 1'b1; pre_a = AW'(a); pre_d = d; ref_mem[a] = d;
    tick();
    pre_we = 1'b0;
  endtask

  task automatic test_reset();
    tick();
    n_cmp++;
    if (main_outs() !== '0) begin
      n_fail++; $display("FAIL reset_outputs: got %h, required 0", main_outs());
    end
    n_cmp++;
    if (l3_outs() !== '0) begin
      n_fail++; $display("FAIL reset_outputs_lat3: got %h, required 0", l3_outs());
    end
    preload(2, 32'h1234_5678);
    preload(4, 32'h0050_0093);
    preload(9, 32'h1234_0000);
    preload(16, 32'hA5A5_0016);
    preload(17, 32'h5A5A_0017);
    rst_n = 1'b1;
    tick();
    tick();
    n_cmp++;
    if (main_outs() !== '0) begin
      n_fail++; $display("FAIL idle_after_reset: got %h, required 0", main_outs());
    end
  endtask

  task automatic test_fetch();
    int c0, at; logic gi, gd, to; logic [31:0] e;
    tick();
    c0 = cyc; if_addr = 32'h10; if_req = 1'b1; q_if.push_back(ref_mem[4]);
    tick();
    n_cmp++;
    if ({mem_en, mem_we, mem_addr} !== {1'b1, 4'b0000, 14'd4}) begin
      n_fail++; $display("FAIL fetch_issue: en/we/addr=%b/%b/%0d, required 1/0000/4", mem_en, mem_we, mem_addr);
    end
    wait_valid(10, at, gi, gd, to);
    if_req = 1'b0;
    n_cmp++;
    if (to || !gi || gd) begin
      n_fail++; $display("FAIL fetch_valid: timeout=%0b if_valid=%0b dm_valid=%0b, required if_valid only", to, gi, gd);
    end
    n_cmp++;
    if (at - c0 != 3) begin
      n_fail++; $display("FAIL fetch_latency: got %0d, required 3", at - c0);
    end
    e = q_if.pop_front();
    n_cmp++;
    if (if_rdata !== e) begin
      n_fail++; $display("FAIL fetch_data: got %h, required %h", if_rdata, e);
    end
  endtask

  task automatic test_store_load();
    int c0, at; logic gi, gd, to; logic [32:0] e;
    tick();
    c0 = cyc; dm_we = 4'b0011; dm_addr = 32'h24; dm_wdata = 32'h0000_BEEF; dm_req = 1'b1;
    ref_mem[9] = merge(ref_mem[9], 32'h0000_BEEF, 4'b0011);
    q_dm.push_back({1'b0, 32'h0});
    tick();
    n_cmp++;
    if ({mem_en, mem_we, mem_addr, mem_wdata} !== {1'b1, 4'b0011, 14'd9, 32'h0000_BEEF}) begin
      n_fail++; $display("FAIL store_issue: en/we/addr/wdata=%b/%b/%0d/%h, required 1/0011/9/0000beef",
                         mem_en, mem_we, mem_addr, mem_wdata);
    end
    wait_valid(10, at, gi, gd, to);
    dm_req = 1'b0; dm_we = 4'b0000;
    n_cmp++;
    if (to || gi || !gd || at - c0 != 2) begin
      n_fail++; $display("FAIL store_done: timeout=%0b if_valid=%0b dm_valid=%0b latency=%0d, required dm_valid at 2",
                         to, gi, gd, at - c0);
    end
    void'(q_dm.pop_front());
    tick();
    c0 = cyc; dm_addr = 32'h24; dm_req = 1'b1; q_dm.push_back({1'b1, ref_mem[9]});
    wait_valid(10, at, gi, gd, to);
    dm_req = 1'b0;
    n_cmp++;
    if (to || gi || !gd || at - c0 != 3) begin
      n_fail++; $display("FAIL load_done: timeout=%0b if_valid=%0b dm_valid=%0b latency=%0d, required dm_valid at 3",
                         to, gi, gd, at - c0);
    end
    e = q_dm.pop_front();
    n_cmp++;
    if (dm_rdata !== e[31:0]) begin
      n_fail++; $display("FAIL load_data: got %h, required %h", dm_rdata, e[31:0]);
    end
    n_cmp++;
    if (dm_rdata[15:0] !== 16'hBEEF) begin
      n_fail++; $display("FAIL load_low_half: got %h, required beef", dm_rdata[15:0]);
    end
  endtask

  task automatic test_back_to_back();
    int at; logic gi, gd, to, want_d; logic [31:0] ei; logic [32:0] ed;
    tick();
    dm_addr = 32'h40; dm_we = 4'b0000; if_addr = 32'h44; dm_req = 1'b1; if_req = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if ((i % 5) != 4) q_dm.push_back({1'b1, ref_mem[16]});
      else q_if.push_back(ref_mem[17]);
    end
    for (int i = 0; i < 10; i++) begin
      want_d = ((i % 5) != 4);
      wait_valid(12, at, gi, gd, to);
      if (i == 9) begin if_req = 1'b0; dm_req = 1'b0; end
      n_cmp++;
      if (to || (gi && gd) || gd != want_d) begin
        n_fail++; $display("FAIL grant_order[%0d]: timeout=%0b if_valid=%0b dm_valid=%0b, required %s",
                           i, to, gi, gd, want_d ? "data" : "fetch");
      end
      if (to) begin if_req = 1'b0; dm_req = 1'b0; break; end
      if (gd && q_dm.size() > 0) begin
        ed = q_dm.pop_front();
        n_cmp++;
        if (dm_rdata !== ed[31:0]) begin
          n_fail++; $display("FAIL b2b_dm_data[%0d]: got %h, required %h", i, dm_rdata, ed[31:0]);
        end
      end
      if (gi && q_if.size() > 0) begin
        ei = q_if.pop_front();
        n_cmp++;
        if (if_rdata !== ei) begin
          n_fail++; $display("FAIL b2b_if_data[%0d]: got %h, required %h", i, if_rdata, ei);
        end
      end
    end
    n_cmp++;
    if (q_if.size() != 0 || q_dm.size() != 0) begin
      n_fail++; $display("FAIL b2b_leftover: if=%0d dm=%0d outstanding, required 0/0", q_if.size(), q_dm.size());
    end
    q_if.delete(); q_dm.delete();
  endtask

  task automatic test_latency3();
    logic [7:0] en_mask; int vat; logic [31:0] got; logic if_seen; logic [32:0] e;
    en_mask = '0; vat = -1; got = '0; if_seen = 1'b0;
    tick();
    l3_dm_addr = 32'h08; l3_dm_we = 4'b0000; l3_dm_req = 1'b1;
    q_dm.push_back({1'b1, ref_mem[2]});
    for (int i = 1; i <= 7; i++) begin
      tick();
      en_mask[i] = l3_mem_en;
      if (l3_if_valid) if_seen = 1'b1;
      if (l3_dm_valid && vat < 0) begin vat = i; got = l3_dm_rdata; l3_dm_req = 1'b0; end
    end
    l3_dm_req = 1'b0;
    n_cmp++;
    if (vat != 5 || if_seen) begin
      n_fail++; $display("FAIL lat3_valid_cycle: dm_valid at %0d if_valid_seen=%0b, required 5/0", vat, if_seen);
    end
    n_cmp++;
    if (en_mask !== 8'b0000_0010) begin
      n_fail++; $display("FAIL lat3_mem_en: cycles %b, required 00000010", en_mask);
    end
    e = q_dm.pop_front();
    n_cmp++;
    if (got !== e[31:0]) begin
      n_fail++; $display("FAIL lat3_data: got %h, required %h", got, e[31:0]);
    end
  endtask

  task automatic test_reset_midflight();
    int c0, at; logic gi, gd, to, stray; logic [31:0] e;
    stray = 1'b0;
    tick();
    if_addr = 32'h10; if_req = 1'b1;
    tick();
    tick();
    rst_n = 1'b0; if_req = 1'b0;
    #1;
    n_cmp++;
    if (main_outs() !== '0) begin
      n_fail++; $display("FAIL async_reset_clear: got %h, required 0", main_outs());
    end
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (if_valid || dm_valid) stray = 1'b1;
    end
    n_cmp++;
    if (stray) begin
      n_fail++; $display("FAIL dropped_txn_valid: stray valid=1, required 0");
    end
    c0 = cyc; if_req = 1'b1; q_if.push_back(ref_mem[4]);
    wait_valid(10, at, gi, gd, to);
    if_req = 1'b0;
    e = q_if.pop_front();
    n_cmp++;
    if (to || !gi || at - c0 != 3 || if_rdata !== e) begin
      n_fail++; $display("FAIL fetch_after_reset: valid=%0b latency=%0d data=%h, required 1/3/%h",
                         gi, at - c0, if_rdata, e);
    end
  endtask

  task automatic test_starvation();
    int at, tx, since_f, dm_raised, dm_done, f_done, guard;
    logic gi, gd, to; logic [31:0] ei; logic [32:0] ed;
    tx = 0; since_f = 0; dm_raised = 0; dm_done = 0; f_done = 0; guard = 0;
    tick();
    if_addr = 32'h44; dm_addr = 32'h40; dm_we = 4'b0000; if_req = 1'b1;
    q_if.push_back(ref_mem[17]);
    while ((q_if.size() > 0 || q_dm.size() > 0) && guard < 40) begin
      guard++;
      wait_valid(4 * (MAXS + 1) * 4, at, gi, gd, to);
      if (to) begin
        n_cmp++; n_fail++;
        $display("FAIL starve_timeout: no valid within budget, required a completion");
        break;
      end
      tx++;
      n_cmp++;
      if (gi && gd) begin
        n_fail++; $display("FAIL starve_dual_valid: if_valid=1 dm_valid=1, required one");
      end
      if (gi) begin
        n_cmp++;
        if (q_if.size() == 0) begin
          n_fail++; $display("FAIL starve_if_unexpected: if_valid with no fetch pending");
        end else begin
          ei = q_if.pop_front();
          if (if_rdata !== ei) begin
            n_fail++; $display("FAIL starve_if_data: got %h, required %h", if_rdata, ei);
          end
        end
        n_cmp++;
        if (since_f >= 4 * (MAXS + 1)) begin
          n_fail++; $display("FAIL starve_gap: %0d transactions before fetch, required < %0d", since_f, 4 * (MAXS + 1));
        end
        since_f = 0; f_done++;
        if (tx < 15) q_if.push_back(ref_mem[17]);
        else if_req = 1'b0;
      end else begin
        since_f++;
      end
      if (gd) begin
        n_cmp++;
        if (q_dm.size() == 0) begin
          n_fail++; $display("FAIL starve_dm_unexpected: dm_valid with no load pending");
        end else begin
          ed = q_dm.pop_front();
          if (dm_rdata !== ed[31:0]) begin
            n_fail++; $display("FAIL starve_dm_data: got %h, required %h", dm_rdata, ed[31:0]);
          end
        end
        dm_req = 1'b0; dm_done++;
      end
      if ((tx % 3) == 0 && !dm_req && tx < 15) begin
        dm_req = 1'b1; q_dm.push_back({1'b1, ref_mem[16]}); dm_raised++;
      end
    end
    if_req = 1'b0; dm_req = 1'b0;
    n_cmp++;
    if (q_if.size() != 0 || q_dm.size() != 0 || dm_done != dm_raised || f_done == 0) begin
      n_fail++; $display("FAIL starve_lost: if_left=%0d dm_left=%0d dm %0d/%0d fetches=%0d, required 0/0 equal >0",
                         q_if.size(), q_dm.size(), dm_done, dm_raised, f_done);
    end
    q_if.delete(); q_dm.delete();
  endtask

  initial begin
    #2 rst_n = 1'b0;
    test_reset();
    test_fetch();
    test_store_load();
    test_back_to_back();
    test_latency3();
    test_reset_midflight();
    test_starvation();
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
